// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache frame geometry, frame record and FSM states.
// The icache frame layout is fixed here, so the icache FRAMES parameter must agree with ICACHE_FRAMES.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_FRAMES = 16;
    localparam int IDX_W = $clog2(ICACHE_FRAMES);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } icache_frame_t;

    typedef enum logic {
        COMPARE = 1'b0,
        FETCH   = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The cache takes the slave view; the datapath/memory harness takes the master view.
interface icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  flush;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame, read-only instruction cache with zero-cycle hits
// and a two-state COMPARE/FETCH miss handler.
module icache
    import cpu_types_pkg::*;
#(
    parameter int FRAMES = 16
) (
    input  logic     CLK,
    input  logic     nRST,
    icache_if.slave  cif
);

    if (FRAMES != (1 << IDX_W)) begin : g_geometry_check
        $error("icache: FRAMES must equal cpu_types_pkg::ICACHE_FRAMES");
    end

    icache_state_t    state, next_state;
    word_t            miss_addr;
    logic             flush_pend;
    logic [FRAMES-1:0] valid;
    logic [TAG_W-1:0] tags [FRAMES];
    word_t            data [FRAMES];

    logic [IDX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0] tag;
    icache_frame_t    frame;
    logic             hit, fill, flush_now;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        idx       = cif.imemaddr[IDX_W+1:2];
        tag       = cif.imemaddr[31:IDX_W+2];
        fill_idx  = miss_addr[IDX_W+1:2];
        frame     = '{valid: valid[idx], tag: tags[idx], data: data[idx]};
        hit       = (state == COMPARE) && cif.imemREN && !cif.flush
                    && frame.valid && (frame.tag == tag);
        fill      = (state == FETCH) && !cif.iwait;
        flush_now = cif.flush || flush_pend;

        next_state = state;
        unique case (state)
            COMPARE: if (cif.imemREN && !cif.flush && !hit) next_state = FETCH;
            FETCH:   if (!cif.iwait) next_state = COMPARE;
            default: next_state = COMPARE;
        endcase

        cif.ihit     = hit;
        cif.imemload = hit ? frame.data : '0;
        cif.iREN     = (state == FETCH);
        cif.iaddr    = miss_addr;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= COMPARE;
            miss_addr  <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= next_state;
            if (state == COMPARE && next_state == FETCH)
                miss_addr <= cif.imemaddr & ~32'd3;
            // A flush seen mid-fill is remembered until the fill edge.
            if (fill)
                flush_pend <= 1'b0;
            else if (state == FETCH && cif.flush)
                flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (state == COMPARE && cif.flush) begin
            valid <= '0;
        end else if (fill) begin
            if (flush_now) valid <= '0;
            else           valid[fill_idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether a frame is usable.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[fill_idx] <= miss_addr[31:IDX_W+2];
            data[fill_idx] <= cif.iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, hit, conflict eviction,
// redirect during fetch, flush (immediate and deferred) and reset during fetch.
module tb_icache;
    import cpu_types_pkg::*;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    icache_if cif ();

    icache #(.FRAMES(16)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .cif  (cif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    // Miss on a, one FETCH cycle with iwait=0 and iload=d; returns positioned at the
    // negedge of the COMPARE cycle after the fill, with a still presented.
    task automatic fill(input word_t a, input word_t d);
        @(negedge clk); cif.imemREN = 1'b1; cif.imemaddr = a; cif.iwait = 1'b1; cif.flush = 1'b0;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = d;
        @(negedge clk); cif.iwait = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cif.imemREN = 1'b1; cif.imemaddr = 32'h0; cif.flush = 1'b0;
        cif.iwait = 1'b1;   cif.iload = 32'h0;
        #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL reset_ihit: got %b want 0", cif.ihit); else passed++;
        total++; if (cif.imemload !== 32'h0) $display("FAIL reset_imemload: got %h want 00000000", cif.imemload); else passed++;
        total++; if (cif.iREN !== 1'b0) $display("FAIL reset_iREN: got %b want 0", cif.iREN); else passed++;
        total++; if (cif.iaddr !== 32'h0) $display("FAIL reset_iaddr: got %h want 00000000", cif.iaddr); else passed++;
        cif.imemREN = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        @(negedge clk); cif.imemREN = 1'b1; cif.imemaddr = 32'h0; cif.iwait = 1'b1; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL cold_miss_ihit: got %b want 0", cif.ihit); else passed++;
        total++; if (cif.iREN !== 1'b0) $display("FAIL cold_compare_iREN: got %b want 0", cif.iREN); else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) begin cif.iwait = 1'b0; cif.iload = 32'h20010005; end
            #1;
            total++;
            if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h0 || cif.ihit !== 1'b0)
                $display("FAIL cold_fetch_cycle%0d: got iREN=%b iaddr=%h ihit=%b want 1 00000000 0", i, cif.iREN, cif.iaddr, cif.ihit);
            else passed++;
        end
        @(negedge clk); cif.iwait = 1'b1; #1;
        total++; if (cif.ihit !== 1'b1) $display("FAIL cold_after_fill_ihit: got %b want 1", cif.ihit); else passed++;
        total++; if (cif.imemload !== 32'h20010005) $display("FAIL cold_after_fill_data: got %h want 20010005", cif.imemload); else passed++;
    endtask

    task automatic test_rehit();
        @(negedge clk); cif.imemaddr = 32'h0; #1;
        total++; if (cif.ihit !== 1'b1) $display("FAIL rehit_ihit: got %b want 1", cif.ihit); else passed++;
        total++; if (cif.iREN !== 1'b0) $display("FAIL rehit_iREN: got %b want 0", cif.iREN); else passed++;
        @(negedge clk); cif.imemREN = 1'b0; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL idle_ihit: got %b want 0", cif.ihit); else passed++;
        total++; if (cif.imemload !== 32'h0) $display("FAIL idle_imemload: got %h want 00000000", cif.imemload); else passed++;
        @(negedge clk); #1;
        total++; if (cif.iREN !== 1'b0) $display("FAIL idle_stays_compare: got iREN=%b want 0", cif.iREN); else passed++;
    endtask

    task automatic test_conflict();
        fill(32'h4, 32'hAAAA0004); #1;
        total++; if (cif.imemload !== 32'hAAAA0004) $display("FAIL conflict_fill4: got %h want AAAA0004", cif.imemload); else passed++;
        @(negedge clk); cif.imemaddr = 32'h44; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL conflict_44_miss: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = 32'hBBBB0044; #1;
        total++; if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h44) $display("FAIL conflict_44_iaddr: got iREN=%b iaddr=%h want 1 00000044", cif.iREN, cif.iaddr); else passed++;
        @(negedge clk); cif.iwait = 1'b1; #1;
        total++; if (cif.ihit !== 1'b1 || cif.imemload !== 32'hBBBB0044) $display("FAIL conflict_44_hit: got ihit=%b data=%h want 1 BBBB0044", cif.ihit, cif.imemload); else passed++;
        @(negedge clk); cif.imemaddr = 32'h4; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL conflict_4_evicted: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = 32'hAAAA0004; #1;
        total++; if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h4) $display("FAIL conflict_4_iaddr: got iREN=%b iaddr=%h want 1 00000004", cif.iREN, cif.iaddr); else passed++;
        @(negedge clk); cif.iwait = 1'b1; cif.imemaddr = 32'h0; #1;
        total++; if (cif.ihit !== 1'b1 || cif.imemload !== 32'h20010005) $display("FAIL conflict_other_index: got ihit=%b data=%h want 1 20010005", cif.ihit, cif.imemload); else passed++;
    endtask

    task automatic test_redirect();
        @(negedge clk); cif.imemaddr = 32'h8; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL redirect_8_miss: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); cif.imemaddr = 32'h100; #1;
        total++; if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h8 || cif.ihit !== 1'b0) $display("FAIL redirect_hold1: got iREN=%b iaddr=%h ihit=%b want 1 00000008 0", cif.iREN, cif.iaddr, cif.ihit); else passed++;
        @(negedge clk); #1;
        total++; if (cif.iaddr !== 32'h8) $display("FAIL redirect_hold2: got iaddr=%h want 00000008", cif.iaddr); else passed++;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = 32'hCCCC0008; #1;
        total++; if (cif.iaddr !== 32'h8) $display("FAIL redirect_hold3: got iaddr=%h want 00000008", cif.iaddr); else passed++;
        @(negedge clk); cif.iwait = 1'b1; #1;
        total++; if (cif.ihit !== 1'b0 || cif.iREN !== 1'b0) $display("FAIL redirect_100_miss: got ihit=%b iREN=%b want 0 0", cif.ihit, cif.iREN); else passed++;
        @(negedge clk); #1;
        total++; if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h100) $display("FAIL redirect_100_iaddr: got iREN=%b iaddr=%h want 1 00000100", cif.iREN, cif.iaddr); else passed++;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = 32'hDDDD0100;
        @(negedge clk); cif.iwait = 1'b1; #1;
        total++; if (cif.ihit !== 1'b1 || cif.imemload !== 32'hDDDD0100) $display("FAIL redirect_100_hit: got ihit=%b data=%h want 1 DDDD0100", cif.ihit, cif.imemload); else passed++;
        @(negedge clk); cif.imemaddr = 32'h8; #1;
        total++; if (cif.ihit !== 1'b1 || cif.imemload !== 32'hCCCC0008) $display("FAIL redirect_8_filled: got ihit=%b data=%h want 1 CCCC0008", cif.ihit, cif.imemload); else passed++;
        @(negedge clk); cif.imemaddr = 32'h0; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL redirect_0_evicted: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = 32'h20010005;
        @(negedge clk); cif.iwait = 1'b1; #1;
        total++; if (cif.ihit !== 1'b1) $display("FAIL redirect_0_refill: got ihit=%b want 1", cif.ihit); else passed++;
    endtask

    task automatic test_flush();
        @(negedge clk); cif.imemaddr = 32'h4; #1;
        total++; if (cif.ihit !== 1'b1) $display("FAIL flush_pre_hit4: got ihit=%b want 1", cif.ihit); else passed++;
        @(negedge clk); cif.flush = 1'b1; cif.imemaddr = 32'h0; #1;
        total++; if (cif.ihit !== 1'b0 || cif.imemload !== 32'h0) $display("FAIL flush_forces_miss: got ihit=%b data=%h want 0 00000000", cif.ihit, cif.imemload); else passed++;
        @(negedge clk); cif.flush = 1'b0; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL flush_0_miss: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = 32'h20010005; #1;
        total++; if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h0) $display("FAIL flush_0_refetch: got iREN=%b iaddr=%h want 1 00000000", cif.iREN, cif.iaddr); else passed++;
        @(negedge clk); cif.iwait = 1'b1; cif.imemaddr = 32'h4; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL flush_4_miss: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = 32'hAAAA0004;
        @(negedge clk); cif.iwait = 1'b1; #1;
        total++; if (cif.ihit !== 1'b1) $display("FAIL flush_4_refill: got ihit=%b want 1", cif.ihit); else passed++;
        // Flush raised during the fill cycle: the fill frame and all others end up invalid.
        @(negedge clk); cif.imemaddr = 32'hC; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL dflush_c_miss: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); cif.flush = 1'b1; cif.iwait = 1'b0; cif.iload = 32'h0EEE000C; #1;
        total++; if (cif.iREN !== 1'b1 || cif.ihit !== 1'b0) $display("FAIL dflush_in_fetch: got iREN=%b ihit=%b want 1 0", cif.iREN, cif.ihit); else passed++;
        @(negedge clk); cif.flush = 1'b0; cif.iwait = 1'b1; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL dflush_fill_invalid: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = 32'hEEEE000C;
        @(negedge clk); cif.iwait = 1'b1; cif.imemaddr = 32'h4; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL dflush_4_cleared: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = 32'hAAAA0004;
        @(negedge clk); cif.iwait = 1'b1; cif.imemaddr = 32'hC; #1;
        total++; if (cif.ihit !== 1'b1 || cif.imemload !== 32'hEEEE000C) $display("FAIL dflush_c_refilled: got ihit=%b data=%h want 1 EEEE000C", cif.ihit, cif.imemload); else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge clk); cif.imemaddr = 32'h20; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL rstfetch_20_miss: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); #1;
        total++; if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h20) $display("FAIL rstfetch_in_fetch: got iREN=%b iaddr=%h want 1 00000020", cif.iREN, cif.iaddr); else passed++;
        #1; rst_n = 1'b0; #1;
        total++; if (cif.iREN !== 1'b0 || cif.iaddr !== 32'h0 || cif.ihit !== 1'b0) $display("FAIL rstfetch_async: got iREN=%b iaddr=%h ihit=%b want 0 00000000 0", cif.iREN, cif.iaddr, cif.ihit); else passed++;
        cif.imemREN = 1'b0; cif.iwait = 1'b0; cif.iload = 32'h12345678;
        @(negedge clk); rst_n = 1'b1; cif.iwait = 1'b1;
        @(negedge clk); cif.imemREN = 1'b1; cif.imemaddr = 32'hC; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL rstfetch_c_cleared: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = 32'hEEEE000C;
        @(negedge clk); cif.iwait = 1'b1; cif.imemaddr = 32'h20; #1;
        total++; if (cif.ihit !== 1'b0) $display("FAIL rstfetch_20_not_written: got ihit=%b want 0", cif.ihit); else passed++;
        @(negedge clk); cif.iwait = 1'b0; cif.iload = 32'hFFFF0020;
        @(negedge clk); cif.iwait = 1'b1; #1;
        total++; if (cif.ihit !== 1'b1 || cif.imemload !== 32'hFFFF0020) $display("FAIL rstfetch_20_fill: got ihit=%b data=%h want 1 FFFF0020", cif.ihit, cif.imemload); else passed++;
        @(negedge clk); cif.imemREN = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_cold_miss();
        test_rehit();
        test_conflict();
        test_redirect();
        test_flush();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter FRAMES, default 16, meaning the number of direct-mapped one-word frames; it must be a power of two.
REQ-002 The block SHALL have port CLK, input, 1 bit: clock, rising-edge.
REQ-003 The block SHALL have port nRST, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port imemREN, input, 1 bit: the fetch side requests an instruction.
REQ-005 The block SHALL have port imemaddr, input, 32 bits (word_t): the fetch byte address.
REQ-006 The block SHALL have port ihit, output, 1 bit: imemload is valid this cycle.
REQ-007 The block SHALL have port imemload, output, 32 bits: the instruction word.
REQ-008 The block SHALL have port flush, input, 1 bit: invalidate all frames.
REQ-009 The block SHALL have port iREN, output, 1 bit: memory read request.
REQ-010 The block SHALL have port iaddr, output, 32 bits: memory read byte address.
REQ-011 The block SHALL have port iwait, input, 1 bit: memory busy; low means iload is valid.
REQ-012 The block SHALL have port iload, input, 32 bits: memory read data.

Function
REQ-013 The address split SHALL be: offset [1:0], ignored; index [IDX_W+1:2], where IDX_W=log2(FRAMES); tag [31:IDX_W+2].
REQ-014 Each frame SHALL hold a valid bit, a tag and a 32-bit data word.
REQ-015 The FSM SHALL have two states: COMPARE and FETCH.
REQ-016 In COMPARE, with imemREN=1, a valid frame and a tag match, ihit SHALL be 1 combinationally in the same cycle and imemload SHALL equal the frame data (zero-cycle hit latency).
REQ-017 In COMPARE, with imemREN=1 and a miss, the FSM SHALL latch imemaddr & ~3 into miss_addr and go to FETCH on the next edge; ihit=0.
REQ-018 In FETCH, iREN SHALL be 1 and iaddr SHALL equal miss_addr, held stable until completion.
REQ-019 In FETCH, when iwait=0, the block SHALL write the frame (valid=1, tag, data=iload) and return to COMPARE on that edge.
REQ-020 ihit SHALL stay 0 throughout FETCH; the re-presented address hits on the cycle after the fill.
REQ-021 If imemaddr changes during FETCH (branch/jump redirect), the fill SHALL complete for miss_addr and the new address is compared in COMPARE.
REQ-022 When imemREN=0 in COMPARE, ihit SHALL be 0, iREN SHALL be 0 and the state SHALL not change.
REQ-023 imemload SHALL be 0 whenever ihit=0.
REQ-024 iREN SHALL be 0 in COMPARE.
REQ-025 flush=1 in COMPARE SHALL clear all valid bits at the edge and force ihit=0 that cycle.
REQ-026 flush=1 in FETCH SHALL be deferred: it clears the valid bits at the fill edge, with the fill frame also left invalid.
REQ-027 A refill to an occupied index SHALL overwrite the previous frame (conflict eviction, no replacement choice).
REQ-028 The block SHALL never write memory.

Reset
REQ-029 nRST low SHALL asynchronously set state=COMPARE, clear all valid bits and set miss_addr=0.
REQ-030 Outputs under reset SHALL be ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-031 Reset during FETCH SHALL abandon the fill, with no frame written.
REQ-032 Tag and data arrays need not be reset.

Structure
REQ-033 The constants IDX_W and TAG_W, the icache_frame_t struct {valid, tag, data} and the icache_state_t enum SHALL live in cpu_types_pkg; word_t is reused.
REQ-034 The block SHALL be a single module; no sub-module is required.

Verification
REQ-035 Reset, then imemREN=1, imemaddr=0x00000000, iwait=1 for 3 cycles then 0 with iload=0x20010005 -> iREN=1 and iaddr=0 for 4 cycles; the next cycle gives ihit=1 and imemload=0x20010005.
REQ-036 Re-fetch 0x00000000 after the fill -> ihit=1 the same cycle, iREN=0.
REQ-037 Fill 0x00000004, then fetch 0x00000044 (same index, different tag) -> miss with iaddr=0x44; a later fetch of 0x04 misses again.
REQ-038 Change imemaddr from 0x08 to 0x100 mid-FETCH -> iaddr stays 0x08 until iwait=0, then 0x100 misses.
REQ-039 flush=1 after filling 0x00 and 0x04 -> both addresses miss afterwards.
REQ-040 Assert nRST low mid-FETCH -> iREN=0 immediately; the address afterwards misses.
